difftest_log_event: RTL and testbench

Per-event performance-counter observer used by the `PERF` instrumentation path in DIFFTEST builds. Each instance watches one free-running counter (`value`) owned by the instrumented module, detects increments, accumulates a wrap-safe 64-bit running total, and produces a snapshot record on request for the difftest host. It sits beside the counter it observes and never feeds back into the core.

---
 rtl/difftest_log_event.sv | 78 +++++++
 tb/tb_difftest_log_event.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/difftest_log_event.sv
// Observes one free-running performance counter, accumulates a wrap-safe total
// of its increments and emits a snapshot record whenever the host asks for one.
module difftest_log_event #(
  parameter string NAME        = "event",
  parameter int    VALUE_WIDTH = 32,
  parameter int    ID_WIDTH    = 8,
  parameter int    TOTAL_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ID_WIDTH-1:0]    coreid,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   dump_req,
  output logic                   change_valid,
  output logic [VALUE_WIDTH-1:0] change_delta,
  output logic [15:0]            wrap_count,
  output logic                   dump_valid,
  output logic [ID_WIDTH-1:0]    dump_coreid,
  output logic [TOTAL_WIDTH-1:0] dump_total,
  output logic [VALUE_WIDTH-1:0] dump_last
);

  logic [VALUE_WIDTH-1:0] prev;
  logic [VALUE_WIDTH-1:0] delta;
  logic [TOTAL_WIDTH-1:0] total;
  logic [TOTAL_WIDTH-1:0] totalNext;
  logic                   changed;
  logic                   wrapped;

  // Modular subtraction gives the right increment across an all-ones wrap.
  assign delta     = value - prev;
  assign changed   = (value != prev);
  assign wrapped   = (value < prev);
  assign totalNext = changed ? total + TOTAL_WIDTH'(delta) : total;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev         <= '0;
      total        <= '0;
      change_valid <= 1'b0;
      change_delta <= '0;
      wrap_count   <= '0;
    end else begin
      prev         <= value;
      total        <= totalNext;
      change_valid <= changed;
      if (changed)
        change_delta <= delta;
      if (wrapped && (wrap_count != 16'hFFFF))
        wrap_count <= wrap_count + 16'd1;
    end
  end

  // The snapshot sees the same-cycle delta so a change and a request coincide cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dump_valid  <= 1'b0;
      dump_coreid <= '0;
      dump_total  <= '0;
      dump_last   <= '0;
    end else if (dump_req) begin
      dump_valid  <= 1'b1;
      dump_coreid <= coreid;
      dump_total  <= totalNext;
      dump_last   <= value;
    end else begin
      dump_valid  <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && dump_valid)
      $display("[%s] core %0d: %0d", NAME, dump_coreid, dump_total);
  end
`endif

endmodule

// File: tb/tb_difftest_log_event.sv
// Vector-table bench for difftest_log_event: each applied record queues its
// expected outputs, which are popped and compared one cycle later.
module tb_difftest_log_event;

  typedef struct {
    logic [31:0] value;
    logic        req;
    logic [7:0]  cid;
    logic        cv;
    logic [31:0] cd;
    logic [15:0] wc;
    logic        dv;
    logic [63:0] dt;
    logic [31:0] dl;
    logic [7:0]  dc;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [7:0]  coreid;
  logic [31:0] value;
  logic        dump_req;
  logic        change_valid;
  logic [31:0] change_delta;
  logic [15:0] wrap_count;
  logic        dump_valid;
  logic [7:0]  dump_coreid;
  logic [63:0] dump_total;
  logic [31:0] dump_last;

  int checks = 0;
  int errors = 0;
  vec_t q[$];
  vec_t vecs[14];

  difftest_log_event dut (
    .clk(clk), .rst(rst), .coreid(coreid), .value(value), .dump_req(dump_req),
    .change_valid(change_valid), .change_delta(change_delta), .wrap_count(wrap_count),
    .dump_valid(dump_valid), .dump_coreid(dump_coreid), .dump_total(dump_total),
    .dump_last(dump_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] v, input logic r, input logic [7:0] c,
                              input logic cv, input logic [31:0] cd, input logic [15:0] wc,
                              input logic dv, input logic [63:0] dt, input logic [31:0] dl,
                              input logic [7:0] dc);
    vec_t x;
    x.value = v; x.req = r; x.cid = c;
    x.cv = cv; x.cd = cd; x.wc = wc; x.dv = dv; x.dt = dt; x.dl = dl; x.dc = dc;
    return x;
  endfunction

  task automatic checkZero(input string nm);
    checks++;
    if ({change_valid, change_delta, wrap_count, dump_valid, dump_coreid, dump_total, dump_last} !== '0) begin
      errors++;
      $display("FAIL %s: got cv=%0d cd=%h wc=%0d dv=%0d dc=%0d dt=%h dl=%h, want all zero",
               nm, change_valid, change_delta, wrap_count, dump_valid, dump_coreid, dump_total, dump_last);
    end
  endtask

  task automatic cmp(input string nm);
    vec_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got nothing to compare against", nm);
      return;
    end
    e = q.pop_front();
    if ({change_valid, change_delta, wrap_count, dump_valid, dump_coreid, dump_total, dump_last} !==
        {e.cv, e.cd, e.wc, e.dv, e.dc, e.dt, e.dl}) begin
      errors++;
      $display("FAIL %s: got cv=%0d cd=%h wc=%0d dv=%0d dc=%0d dt=%h dl=%h, want cv=%0d cd=%h wc=%0d dv=%0d dc=%0d dt=%h dl=%h",
               nm, change_valid, change_delta, wrap_count, dump_valid, dump_coreid, dump_total, dump_last,
               e.cv, e.cd, e.wc, e.dv, e.dc, e.dt, e.dl);
    end
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled #1 after the next one.
  task automatic apply(input vec_t v, input string nm);
    value = v.value; dump_req = v.req; coreid = v.cid;
    q.push_back(v);
    @(posedge clk); #1;
    cmp(nm);
  endtask

  task automatic pulseReset(input logic [31:0] v, input string nm);
    value = v; dump_req = 1'b0; coreid = 8'd0;
    rst = 1'b0;
    #1 checkZero(nm);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(32'd0,          0, 8'd0, 0, 32'd0,          16'd0, 0, 64'd0,           32'd0,          8'd0);
    vecs[1]  = mk(32'd1,          0, 8'd0, 1, 32'd1,          16'd0, 0, 64'd0,           32'd0,          8'd0);
    vecs[2]  = mk(32'd3,          0, 8'd0, 1, 32'd2,          16'd0, 0, 64'd0,           32'd0,          8'd0);
    vecs[3]  = mk(32'd3,          0, 8'd0, 0, 32'd2,          16'd0, 0, 64'd0,           32'd0,          8'd0);
    vecs[4]  = mk(32'd3,          1, 8'd0, 0, 32'd2,          16'd0, 1, 64'd3,           32'd3,          8'd0);
    vecs[5]  = mk(32'hFFFF_FFFE,  1, 8'd0, 1, 32'hFFFF_FFFB,  16'd0, 1, 64'hFFFF_FFFE,   32'hFFFF_FFFE,  8'd0);
    vecs[6]  = mk(32'h0000_0002,  1, 8'd0, 1, 32'd4,          16'd1, 1, 64'h1_0000_0002, 32'd2,          8'd0);
    vecs[7]  = mk(32'd10,         0, 8'd3, 1, 32'd8,          16'd1, 0, 64'h1_0000_0002, 32'd2,          8'd0);
    vecs[8]  = mk(32'd15,         1, 8'd3, 1, 32'd5,          16'd1, 1, 64'h1_0000_000F, 32'd15,         8'd3);
    vecs[9]  = mk(32'd16,         1, 8'd3, 1, 32'd1,          16'd1, 1, 64'h1_0000_0010, 32'd16,         8'd3);
    vecs[10] = mk(32'd17,         1, 8'd3, 1, 32'd1,          16'd1, 1, 64'h1_0000_0011, 32'd17,         8'd3);
    vecs[11] = mk(32'd18,         1, 8'd3, 1, 32'd1,          16'd1, 1, 64'h1_0000_0012, 32'd18,         8'd3);
    vecs[12] = mk(32'd19,         1, 8'd3, 1, 32'd1,          16'd1, 1, 64'h1_0000_0013, 32'd19,         8'd3);
    vecs[13] = mk(32'd19,         0, 8'd0, 0, 32'd1,          16'd1, 0, 64'h1_0000_0013, 32'd19,         8'd3);

    // Reset held with a live counter and an active request.
    rst = 1'b0; value = 32'd5; dump_req = 1'b1; coreid = 8'd0;
    repeat (2) @(posedge clk);
    #1 checkZero("reset_hold");
    value = 32'd0; dump_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Mid-run reset: the total is rebuilt from prev = 0.
    pulseReset(32'd0, "reset_pre_accum");
    apply(mk(32'd40,  0, 8'd0, 1, 32'd40,  16'd0, 0, 64'd0,   32'd0,   8'd0), "accum40");
    apply(mk(32'd100, 1, 8'd0, 1, 32'd60,  16'd0, 1, 64'd100, 32'd100, 8'd0), "accum100");
    pulseReset(32'd100, "reset_midrun");
    apply(mk(32'd100, 1, 8'd0, 1, 32'd100, 16'd0, 1, 64'd100, 32'd100, 8'd0), "after_reset_dump");
    apply(mk(32'd100, 0, 8'd0, 0, 32'd100, 16'd0, 0, 64'd100, 32'd100, 8'd0), "after_reset_idle");

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
